// File: rtl/packet_framer_if.sv
// rtl/packet_framer_if.sv - handshake bundle between a packet source, the framer and the parser
//
// Purpose: carries the command, payload and framed-output streams of
//          packet_framer as one interface.
// Signals:
//    cmd_val/cmd_ready/cmd_stream/cmd_length/cmd_err : packet command channel
//    pay_data/pay_val/pay_ready                      : payload word channel
//    dataOut/dataOut_val/dataOut_ready/dataOut_last  : framed output channel
//    busy                                            : framer not idle
//    inject_gap                                      : sequence-gap request,
//                                                      only with PACKET_FRAMER_GAP_INJECT_EN
// Modports: slave  = framer side, master = source/sink side.
// Configuration macro: PACKET_FRAMER_GAP_INJECT_EN

interface packet_framer_if;
   logic        cmd_val;
   logic        cmd_ready;
   logic [15:0] cmd_stream;
   logic [15:0] cmd_length;
   logic        cmd_err;
   logic [31:0] pay_data;
   logic        pay_val;
   logic        pay_ready;
   logic [31:0] dataOut;
   logic        dataOut_val;
   logic        dataOut_ready;
   logic        dataOut_last;
   logic        busy;
`ifdef PACKET_FRAMER_GAP_INJECT_EN
   logic        inject_gap;
`endif

   modport slave (
`ifdef PACKET_FRAMER_GAP_INJECT_EN
      input  inject_gap,
`endif
      input  cmd_val,
      output cmd_ready,
      input  cmd_stream,
      input  cmd_length,
      output cmd_err,
      input  pay_data,
      input  pay_val,
      output pay_ready,
      output dataOut,
      output dataOut_val,
      input  dataOut_ready,
      output dataOut_last,
      output busy
   );

   modport master (
`ifdef PACKET_FRAMER_GAP_INJECT_EN
      output inject_gap,
`endif
      output cmd_val,
      input  cmd_ready,
      output cmd_stream,
      output cmd_length,
      input  cmd_err,
      output pay_data,
      output pay_val,
      input  pay_ready,
      input  dataOut,
      input  dataOut_val,
      output dataOut_ready,
      input  dataOut_last,
      input  busy
   );
endinterface

// File: rtl/packet_framer.sv
// rtl/packet_framer.sv - prepends a two-word stream/sequence header to each packet
//
// Purpose: accepts one packet command at a time, emits a length/stream header
//          word, a per-stream sequence-number word, then passes W-2 payload
//          words straight through (W = cmd_length / 4, remainder bytes dropped).
// Ports:
//    clk   : single clock, rising edge
//    reset : asynchronous, active-high
//    bus   : packet_framer_if.slave (command, payload and framed-output channels)
// Parameter: NUM_STREAMS - number of per-stream sequence counters (power of 2, 2..256)
// Configuration macro: PACKET_FRAMER_GAP_INJECT_EN - adds bus.inject_gap; when
//          high at acceptance the sequence number skips by two.

module packet_framer #(
   parameter int NUM_STREAMS = 8
) (
   input logic            clk,
   input logic            reset,
   packet_framer_if.slave bus
);

   localparam int IDX_W = (NUM_STREAMS > 1) ? $clog2(NUM_STREAMS) : 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      HDR0    = 2'd1,
      HDR1    = 2'd2,
      PAYLOAD = 2'd3
   } state_t;

   state_t      r_state;
   state_t      w_next_state;

   logic [31:0] r_ctr [NUM_STREAMS];
   logic [31:0] r_hdr0;
   logic [31:0] r_hdr1;
   logic [13:0] r_rem;
   logic        r_cmd_err;

   logic             w_cmd_ready;
   logic             w_accept;
   logic             w_short;
   logic [13:0]      w_words;
   logic [IDX_W-1:0] w_idx;
   logic [31:0]      w_seq_inc;
   logic [31:0]      w_seq;
   logic             w_out_val;
   logic             w_xfer;
   logic             w_last;

   // Ready is masked by reset so it reads 0 while reset is held, even though
   // the state register already sits at IDLE.
   assign w_cmd_ready = (r_state == IDLE) && !reset;
   assign w_accept    = bus.cmd_val && w_cmd_ready;
   assign w_words     = bus.cmd_length[15:2];
   assign w_short     = (w_words < 14'd2);
   assign w_idx       = bus.cmd_stream[IDX_W-1:0];

`ifdef PACKET_FRAMER_GAP_INJECT_EN
   assign w_seq_inc = bus.inject_gap ? 32'd2 : 32'd1;
`else
   assign w_seq_inc = 32'd1;
`endif

   // 32-bit add wraps FFFFFFFF -> 0 naturally.
   assign w_seq = r_ctr[w_idx] + w_seq_inc;

   // r_rem counts words still to be sent, including the one on the bus now.
   assign w_last    = (r_rem == 14'd1);
   assign w_out_val = (r_state == HDR0) || (r_state == HDR1) ||
                      ((r_state == PAYLOAD) && bus.pay_val);
   assign w_xfer    = w_out_val && bus.dataOut_ready;

   assign bus.cmd_err = r_cmd_err;

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next state and output decode.
   always_comb begin
      w_next_state     = r_state;
      bus.cmd_ready    = 1'b0;
      bus.pay_ready    = 1'b0;
      bus.dataOut      = 32'd0;
      bus.dataOut_val  = 1'b0;
      bus.dataOut_last = 1'b0;
      bus.busy         = 1'b0;
      case (r_state)
         IDLE: begin
            bus.cmd_ready = w_cmd_ready;
            if (w_accept && !w_short) begin
               w_next_state = HDR0;
            end
         end
         HDR0: begin
            bus.busy        = 1'b1;
            bus.dataOut     = r_hdr0;
            bus.dataOut_val = 1'b1;
            // W >= 2 here, so the first header word is never the last.
            if (w_xfer) begin
               w_next_state = HDR1;
            end
         end
         HDR1: begin
            bus.busy         = 1'b1;
            bus.dataOut      = r_hdr1;
            bus.dataOut_val  = 1'b1;
            bus.dataOut_last = w_last;
            if (w_xfer) begin
               w_next_state = w_last ? IDLE : PAYLOAD;
            end
         end
         PAYLOAD: begin
            // Zero-latency pass-through; the source sees the sink's ready directly.
            bus.busy         = 1'b1;
            bus.dataOut      = bus.pay_data;
            bus.dataOut_val  = bus.pay_val;
            bus.pay_ready    = bus.dataOut_ready;
            bus.dataOut_last = w_last && bus.pay_val;
            if (w_xfer && w_last) begin
               w_next_state = IDLE;
            end
         end
         default: begin
            w_next_state = IDLE;
         end
      endcase
   end

   // Header, word counter, sequence counters and reject pulse.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_hdr0    <= 32'd0;
         r_hdr1    <= 32'd0;
         r_rem     <= 14'd0;
         r_cmd_err <= 1'b0;
         for (int i = 0; i < NUM_STREAMS; i++) begin
            r_ctr[i] <= 32'd0;
         end
      end else begin
         r_cmd_err <= w_accept && w_short;
         if (w_accept && !w_short) begin
            // Both header words are byte-swapped into little-endian order.
            r_hdr0       <= {bus.cmd_length[7:0], bus.cmd_length[15:8],
                             bus.cmd_stream[7:0], bus.cmd_stream[15:8]};
            r_hdr1       <= {w_seq[7:0], w_seq[15:8], w_seq[23:16], w_seq[31:24]};
            r_ctr[w_idx] <= w_seq;
            r_rem        <= w_words;
         end else if (w_xfer) begin
            r_rem <= r_rem - 14'd1;
         end
      end
   end

endmodule

// File: tb/tb_packet_framer.sv
// tb/tb_packet_framer.sv - directed self-checking bench for packet_framer

module tb_packet_framer;

   logic clk;
   logic reset;

   packet_framer_if bus();

   packet_framer #(.NUM_STREAMS(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_pass;
   int          n_total;
   logic [31:0] q_data [$];
   logic        q_last [$];
   logic [31:0] q_stall [$];
   logic        saw_pay_ready;
   logic        timed_out;
   logic        cmd_was_ready;
   logic [31:0] pay_idx;

   task automatic send_cmd(input logic [15:0] s, input logic [15:0] l);
      @(negedge clk);
      bus.cmd_val    = 1'b1;
      bus.cmd_stream = s;
      bus.cmd_length = l;
      #1;
      cmd_was_ready = bus.cmd_ready;
      @(posedge clk);
      #1;
      bus.cmd_val = 1'b0;
   endtask

   task automatic collect(input int budget, input int stall_cycles);
      int   cyc;
      logic done;
      logic pay_xfer;
      q_data.delete();
      q_last.delete();
      q_stall.delete();
      saw_pay_ready = 1'b0;
      timed_out     = 1'b0;
      pay_idx       = 32'd0;
      cyc           = 0;
      done          = 1'b0;
      while (!done && cyc < budget) begin
         @(negedge clk);
         bus.dataOut_ready = (cyc >= stall_cycles);
         bus.pay_data      = 32'hA000_0000 + pay_idx;
         #1;
         pay_xfer = bus.pay_ready && bus.pay_val;
         if (bus.pay_ready) saw_pay_ready = 1'b1;
         if (bus.dataOut_val && bus.dataOut_ready) begin
            q_data.push_back(bus.dataOut);
            q_last.push_back(bus.dataOut_last);
            if (bus.dataOut_last) done = 1'b1;
         end else if (bus.dataOut_val) begin
            q_stall.push_back(bus.dataOut);
         end
         @(posedge clk);
         if (pay_xfer) pay_idx = pay_idx + 32'd1;
         cyc++;
      end
      bus.dataOut_ready = 1'b1;
      if (!done) timed_out = 1'b1;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_total++; if (bus.cmd_ready !== 1'b0) $display("FAIL rst_cmd_ready got %0b want 0", bus.cmd_ready); else n_pass++;
      n_total++; if (bus.dataOut_val !== 1'b0) $display("FAIL rst_val got %0b want 0", bus.dataOut_val); else n_pass++;
      n_total++; if (bus.dataOut !== 32'd0) $display("FAIL rst_data got %h want 0", bus.dataOut); else n_pass++;
      n_total++; if ({bus.busy, bus.pay_ready, bus.cmd_err, bus.dataOut_last} !== 4'b0) $display("FAIL rst_misc got %b want 0000", {bus.busy, bus.pay_ready, bus.cmd_err, bus.dataOut_last}); else n_pass++;
      reset = 1'b0;
      #1;
      n_total++; if (bus.cmd_ready !== 1'b1) $display("FAIL idle_cmd_ready got %0b want 1", bus.cmd_ready); else n_pass++;
      n_total++; if (bus.busy !== 1'b0) $display("FAIL idle_busy got %0b want 0", bus.busy); else n_pass++;
   endtask

   task automatic test_basic_packet;
      send_cmd(16'd12, 16'd20);
      n_total++; if (cmd_was_ready !== 1'b1) $display("FAIL basic_accept got %0b want 1", cmd_was_ready); else n_pass++;
      collect(30, 0);
      n_total++; if (timed_out !== 1'b0) $display("FAIL basic_timeout got %0b want 0", timed_out); else n_pass++;
      n_total++; if (q_data.size() !== 5) $display("FAIL basic_count got %0d want 5", q_data.size()); else n_pass++;
      n_total++; if (q_data[0] !== 32'h1400_0C00) $display("FAIL basic_hdr0 got %h want 14000c00", q_data[0]); else n_pass++;
      n_total++; if (q_data[1] !== 32'h0100_0000) $display("FAIL basic_hdr1 got %h want 01000000", q_data[1]); else n_pass++;
      for (int i = 0; i < 3; i++) begin
         n_total++; if (q_data[2+i] !== 32'hA000_0000 + i) $display("FAIL basic_pay%0d got %h want %h", i, q_data[2+i], 32'hA000_0000 + i); else n_pass++;
      end
      n_total++; if ({q_last[0], q_last[1], q_last[2], q_last[3], q_last[4]} !== 5'b00001) $display("FAIL basic_last got %b want 00001", {q_last[0], q_last[1], q_last[2], q_last[3], q_last[4]}); else n_pass++;
      #1;
      n_total++; if (bus.cmd_ready !== 1'b1) $display("FAIL basic_ready_back got %0b want 1", bus.cmd_ready); else n_pass++;
   endtask

   task automatic test_min_length;
      send_cmd(16'd12, 16'd8);
      collect(20, 0);
      n_total++; if (timed_out !== 1'b0) $display("FAIL min_timeout got %0b want 0", timed_out); else n_pass++;
      n_total++; if (q_data.size() !== 2) $display("FAIL min_count got %0d want 2", q_data.size()); else n_pass++;
      n_total++; if (q_data[0] !== 32'h0800_0C00) $display("FAIL min_hdr0 got %h want 08000c00", q_data[0]); else n_pass++;
      n_total++; if (q_data[1] !== 32'h0200_0000) $display("FAIL min_hdr1 got %h want 02000000", q_data[1]); else n_pass++;
      n_total++; if ({q_last[0], q_last[1]} !== 2'b01) $display("FAIL min_last got %b want 01", {q_last[0], q_last[1]}); else n_pass++;
      n_total++; if (saw_pay_ready !== 1'b0) $display("FAIL min_pay_ready got %0b want 0", saw_pay_ready); else n_pass++;
   endtask

   task automatic test_short_cmd;
      send_cmd(16'd12, 16'd7);
      n_total++; if (bus.cmd_err !== 1'b1) $display("FAIL short_err got %0b want 1", bus.cmd_err); else n_pass++;
      n_total++; if (bus.dataOut_val !== 1'b0) $display("FAIL short_val got %0b want 0", bus.dataOut_val); else n_pass++;
      n_total++; if (bus.busy !== 1'b0) $display("FAIL short_busy got %0b want 0", bus.busy); else n_pass++;
      @(posedge clk);
      #1;
      n_total++; if (bus.cmd_err !== 1'b0) $display("FAIL short_err_pulse got %0b want 0", bus.cmd_err); else n_pass++;
      n_total++; if (bus.dataOut_val !== 1'b0) $display("FAIL short_val2 got %0b want 0", bus.dataOut_val); else n_pass++;
      send_cmd(16'd12, 16'd8);
      collect(20, 0);
      n_total++; if (q_data[1] !== 32'h0300_0000) $display("FAIL short_ctr got %h want 03000000", q_data[1]); else n_pass++;
   endtask

   task automatic test_backpressure;
      send_cmd(16'd14, 16'd39);
      collect(40, 3);
      n_total++; if (timed_out !== 1'b0) $display("FAIL bp_timeout got %0b want 0", timed_out); else n_pass++;
      n_total++; if (q_stall.size() !== 3) $display("FAIL bp_stall_count got %0d want 3", q_stall.size()); else n_pass++;
      for (int i = 0; i < 3; i++) begin
         n_total++; if (q_stall[i] !== 32'h2700_0E00) $display("FAIL bp_hold%0d got %h want 27000e00", i, q_stall[i]); else n_pass++;
      end
      n_total++; if (q_data.size() !== 9) $display("FAIL bp_count got %0d want 9", q_data.size()); else n_pass++;
      n_total++; if (q_data[0] !== 32'h2700_0E00) $display("FAIL bp_hdr0 got %h want 27000e00", q_data[0]); else n_pass++;
      n_total++; if (q_data[1] !== 32'h0100_0000) $display("FAIL bp_hdr1 got %h want 01000000", q_data[1]); else n_pass++;
      n_total++; if (q_data[8] !== 32'hA000_0006) $display("FAIL bp_lastpay got %h want a0000006", q_data[8]); else n_pass++;
      n_total++; if (q_last[8] !== 1'b1 || q_last[7] !== 1'b0) $display("FAIL bp_last got %b%b want 01", q_last[7], q_last[8]); else n_pass++;
      n_total++; if (pay_idx !== 32'd7) $display("FAIL bp_consumed got %0d want 7", pay_idx); else n_pass++;
   endtask

`ifdef PACKET_FRAMER_GAP_INJECT_EN
   task automatic test_gap_inject;
      send_cmd(16'd13, 16'd12);
      collect(20, 0);
      n_total++; if (q_data[1] !== 32'h0100_0000) $display("FAIL gap_first got %h want 01000000", q_data[1]); else n_pass++;
      bus.inject_gap = 1'b1;
      send_cmd(16'd13, 16'd12);
      bus.inject_gap = 1'b0;
      collect(20, 0);
      n_total++; if (q_data[1] !== 32'h0300_0000) $display("FAIL gap_second got %h want 03000000", q_data[1]); else n_pass++;
   endtask
`endif

   task automatic test_reset_mid_packet;
      send_cmd(16'd15, 16'd20);
      bus.dataOut_ready = 1'b1;
      repeat (2) @(posedge clk);
      #2;
      n_total++; if (bus.pay_ready !== 1'b1) $display("FAIL mid_in_payload got %0b want 1", bus.pay_ready); else n_pass++;
      reset = 1'b1;
      #1;
      n_total++; if (bus.dataOut_val !== 1'b0) $display("FAIL mid_val got %0b want 0", bus.dataOut_val); else n_pass++;
      n_total++; if (bus.dataOut !== 32'd0) $display("FAIL mid_data got %h want 0", bus.dataOut); else n_pass++;
      n_total++; if ({bus.busy, bus.pay_ready, bus.cmd_ready, bus.dataOut_last} !== 4'b0) $display("FAIL mid_misc got %b want 0000", {bus.busy, bus.pay_ready, bus.cmd_ready, bus.dataOut_last}); else n_pass++;
      @(posedge clk);
      #1;
      n_total++; if (bus.dataOut_val !== 1'b0) $display("FAIL mid_val_held got %0b want 0", bus.dataOut_val); else n_pass++;
      @(negedge clk);
      reset = 1'b0;
      send_cmd(16'd15, 16'd8);
      collect(20, 0);
      n_total++; if (q_data[1] !== 32'h0100_0000) $display("FAIL mid_seq got %h want 01000000", q_data[1]); else n_pass++;
   endtask

   initial begin
      n_pass            = 0;
      n_total           = 0;
      reset             = 1'b1;
      bus.cmd_val       = 1'b0;
      bus.cmd_stream    = 16'd0;
      bus.cmd_length    = 16'd0;
      bus.pay_data      = 32'd0;
      bus.pay_val       = 1'b1;
      bus.dataOut_ready = 1'b1;
`ifdef PACKET_FRAMER_GAP_INJECT_EN
      bus.inject_gap    = 1'b0;
`endif
      test_reset();
      test_basic_packet();
      test_min_length();
      test_short_cmd();
      test_backpressure();
`ifdef PACKET_FRAMER_GAP_INJECT_EN
      test_gap_inject();
`endif
      test_reset_mid_packet();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/packet_framer.md
PACKET_FRAMER -- requirements
Module: packet_framer

Interface
REQ-001 Parameter: NUM_STREAMS, 8, number of per-stream sequence counters (power of 2, 2..256).
REQ-002 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 Port: reset  in  1  asynchronous, active-high reset.
REQ-004 Port: cmd_val  in  1  packet command valid.
REQ-005 Port: cmd_ready  out  1  command accepted when cmd_val && cmd_ready.
REQ-006 Port: cmd_stream  in  16  stream id.
REQ-007 Port: cmd_length  in  16  packet length in bytes, header included.
REQ-008 Port: cmd_err  out  1  one-cycle pulse: command rejected.
REQ-009 Port: pay_data  in  32  payload word.
REQ-010 Port: pay_val  in  1  payload word valid.
REQ-011 Port: pay_ready  out  1  payload word consumed when pay_val && pay_ready.
REQ-012 Port: dataOut  out  32  framed word to the parser dataIn.
REQ-013 Port: dataOut_val  out  1  framed word valid.
REQ-014 Port: dataOut_ready  in  1  downstream ready (parser dataIn_ready).
REQ-015 Port: dataOut_last  out  1  final word of packet (parser dataIN_last).
REQ-016 Port: busy  out  1  high in any state other than IDLE.

Function
REQ-017 FSM states IDLE, HDR0, HDR1, PAYLOAD; the block resets to IDLE.
REQ-018 cmd_ready SHALL be 1 only in IDLE; all other outputs stay 0 in IDLE except cmd_err.
REQ-019 Word count W = cmd_length[15:2] (floor of length/4); a command with W<2 SHALL be dropped with cmd_err=1 the cycle after acceptance, FSM stays IDLE, and no counter update occurs.
REQ-020 On a valid accept at edge N, the block latches stream, length, and seq = ctr[stream mod NUM_STREAMS]+1 (32-bit wrap FFFFFFFF->0), writes seq back to the counter, and enters HDR0; dataOut_val=1 from cycle N+1.
REQ-021 HDR0 dataOut = {length[7:0], length[15:8], stream[7:0], stream[15:8]} (little-endian, length in upper half).
REQ-022 HDR1 dataOut = {seq[7:0], seq[15:8], seq[23:16], seq[31:24]}.
REQ-023 Header words SHALL be registered and held stable while dataOut_val && !dataOut_ready.
REQ-024 HDR0->HDR1 and HDR1->PAYLOAD (or HDR1->IDLE when W=2) SHALL occur only on dataOut_val && dataOut_ready.
REQ-025 In PAYLOAD: dataOut=pay_data, dataOut_val=pay_val, pay_ready=dataOut_ready (combinational pass-through, zero latency); pay_ready=0 in all other states.
REQ-026 A down-counter SHALL track remaining words; dataOut_last=1 exactly on word W-1 (HDR1 when W=2); on its transfer the FSM returns to IDLE and cmd_ready=1 the next cycle.
REQ-027 Trailing bytes (length mod 4) SHALL NOT be emitted; no payload word beyond W-2 is consumed.
REQ-028 Commands are not queued; one packet is in flight at a time.

Reset
REQ-029 While reset=1: FSM=IDLE, all counters 0, cmd_ready=0, cmd_err=0, dataOut_val=0, dataOut_last=0, pay_ready=0, busy=0, dataOut=0.
REQ-030 Reset mid-packet SHALL abort immediately with no further output words; the seq counter write from that packet is discarded (counter returns to 0).

Configuration
REQ-031 Macro PACKET_FRAMER_GAP_INJECT_EN: when defined, a 1-bit input inject_gap is added; if high at command acceptance, seq = ctr+2 and ctr is written with ctr+2, producing a sequence gap that the downstream packetLost detection must flag.
REQ-032 When not defined, the port does not exist and seq always = ctr+1.

Verification
REQ-033 After reset, cmd(stream=12,len=20), dataOut_ready=1 -> words 0x14000C00, 0x01000000, 3 payload words, last on 5th, cmd_ready back next cycle.
REQ-034 Second cmd(stream=12,len=8) -> 0x08000C00, 0x02000000 with dataOut_last on the 2nd word; pay_ready never asserted.
REQ-035 cmd(len=7) -> cmd_err pulse one cycle, no dataOut_val, stream counter unchanged.
REQ-036 cmd(stream=14,len=39) with dataOut_ready low 3 cycles in HDR0 -> 0x27000E00 held stable; then 9 words total, trailing 3 bytes dropped.
REQ-037 With PACKET_FRAMER_GAP_INJECT_EN, cmd(stream=13,len=12) then cmd(stream=13,len=12,inject_gap=1) -> seq words 0x01000000 then 0x03000000.
REQ-038 Reset asserted during PAYLOAD -> outputs 0 asynchronously; next cmd on same stream yields seq 0x01000000.
